// File: rtl/event_packet_framer_if.sv
// rtl/event_packet_framer_if.sv - AXI-Stream style bundle for the framer's event input and packet output
interface event_packet_framer_if #(
    parameter int TDATA_WIDTH = 64
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic                   tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/event_packet_framer.sv
// rtl/event_packet_framer.sv - buffers whole trigger events and emits header+payload packets; FRAMER_FOOTER_EN adds a checksum footer
module event_packet_framer #(
    parameter int          TDATA_WIDTH     = 64,
    parameter int          FIFO_DEPTH      = 256,
    parameter int          MAX_EVENT_WORDS = 128,
    parameter int          LEN_FIFO_DEPTH  = 8,
    parameter logic [7:0]  CHANNEL_ID      = 8'h00,
    parameter logic [15:0] HEADER_MAGIC    = 16'hAA55
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESET,
    event_packet_framer_if.slave          s_axis,
    event_packet_framer_if.master         m_axis,
    output logic [31:0]                   O_EVENT_COUNT,
    output logic [15:0]                   O_DROP_COUNT,
    output logic                          O_OVERFLOW
);

    localparam int PAW = $clog2(FIFO_DEPTH);
    localparam int LAW = $clog2(LEN_FIFO_DEPTH);

    // An event is admitted only if a worst-case (maximum length) event still fits.
    localparam logic [PAW:0] FILL_LIMIT = (PAW + 1)'(FIFO_DEPTH - MAX_EVENT_WORDS);
    localparam logic [LAW:0] LEN_FULL   = (LAW + 1)'(LEN_FIFO_DEPTH);
    localparam logic [15:0]  MAX_WORDS  = 16'(MAX_EVENT_WORDS);

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_CAPTURE,
        IN_DISCARD
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_HEADER,
        OUT_PAYLOAD,
        OUT_FOOTER
    } out_state_t;

    typedef struct packed {
        logic [15:0] len;
        logic        tuser;
        logic        trunc;
    } len_entry_t;

    // Payload FIFO
    logic [TDATA_WIDTH-1:0] pay_mem [FIFO_DEPTH];
    logic [PAW-1:0]         pay_wr_ptr;
    logic [PAW-1:0]         pay_rd_ptr;
    logic [PAW:0]           pay_count;
    logic                   pay_wr;
    logic                   pay_rd;

    // Length FIFO: one entry per complete event ready to be framed
    len_entry_t             len_mem [LEN_FIFO_DEPTH];
    logic [LAW-1:0]         len_wr_ptr;
    logic [LAW-1:0]         len_rd_ptr;
    logic [LAW:0]           len_count;
    logic                   len_push;
    logic                   len_pop;
    len_entry_t             push_entry;

    // Input side
    in_state_t              in_state;
    in_state_t              in_next;
    logic                   in_ready;
    logic                   in_accept;
    logic                   room;
    logic [15:0]            word_cnt;
    logic [15:0]            next_cnt;
    logic                   cur_tuser;
    logic                   cur_trunc;
    logic                   set_trunc;
    logic                   drop;

    // Output side
    out_state_t             out_state;
    out_state_t             out_next;
    len_entry_t             hdr_q;
    logic [15:0]            out_cnt;
    logic [15:0]            seq;
    logic                   last_payload;
    logic                   pkt_done;
    logic [63:0]            hdr_word;
    logic [TDATA_WIDTH-1:0] out_data;
    logic                   out_valid;
    logic                   out_last;
    logic [31:0]            event_count;
    logic [15:0]            drop_count;
    logic                   overflow;

`ifdef FRAMER_FOOTER_EN
    logic [31:0]            xor_acc;
    logic [63:0]            footer_word;
`endif

    assign in_accept = s_axis.tvalid && in_ready;
    assign room      = (pay_count <= FILL_LIMIT) && (len_count != LEN_FULL);
    assign next_cnt  = word_cnt + 16'd1;

    assign s_axis.tready = in_ready;
    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign m_axis.tuser  = 1'b0;

    assign O_EVENT_COUNT = event_count;
    assign O_DROP_COUNT  = drop_count;
    assign O_OVERFLOW    = overflow;

    // Input never stalls: ready rises once reset is released and stays high.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) in_ready <= 1'b0;
        else             in_ready <= 1'b1;
    end

    // Input FSM state register.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) in_state <= IN_IDLE;
        else             in_state <= in_next;
    end

    // Input FSM: admit or drop an event on its first word, capture, truncate, push its length on TLAST.
    always_comb begin
        in_next          = in_state;
        pay_wr           = 1'b0;
        len_push         = 1'b0;
        drop             = 1'b0;
        set_trunc        = 1'b0;
        push_entry.len   = next_cnt;
        push_entry.tuser = cur_tuser;
        push_entry.trunc = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (in_accept) begin
                    if (room) begin
                        pay_wr = 1'b1;
                        if (s_axis.tlast) begin
                            len_push         = 1'b1;
                            push_entry.len   = 16'd1;
                            push_entry.tuser = s_axis.tuser;
                        end else if (MAX_WORDS == 16'd1) begin
                            set_trunc = 1'b1;
                            in_next   = IN_DISCARD;
                        end else begin
                            in_next = IN_CAPTURE;
                        end
                    end else begin
                        drop = 1'b1;
                        if (!s_axis.tlast) in_next = IN_DISCARD;
                    end
                end
            end
            IN_CAPTURE: begin
                if (in_accept) begin
                    pay_wr = 1'b1;
                    if (s_axis.tlast) begin
                        len_push = 1'b1;
                        in_next  = IN_IDLE;
                    end else if (next_cnt == MAX_WORDS) begin
                        set_trunc = 1'b1;
                        in_next   = IN_DISCARD;
                    end
                end
            end
            IN_DISCARD: begin
                if (in_accept && s_axis.tlast) begin
                    in_next = IN_IDLE;
                    // A dropped event has cur_trunc clear and leaves no trace in the length FIFO.
                    if (cur_trunc) begin
                        len_push         = 1'b1;
                        push_entry.len   = word_cnt;
                        push_entry.trunc = 1'b1;
                    end
                end
            end
            default: in_next = IN_IDLE;
        endcase
    end

    // Per-event capture context: words written, TUSER of the first word, truncation flag.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            word_cnt  <= 16'd0;
            cur_tuser <= 1'b0;
            cur_trunc <= 1'b0;
        end else if (in_state == IN_IDLE && in_accept) begin
            word_cnt  <= 16'd1;
            cur_tuser <= s_axis.tuser;
            cur_trunc <= set_trunc;
        end else begin
            if (pay_wr)    word_cnt  <= next_cnt;
            if (set_trunc) cur_trunc <= 1'b1;
        end
    end

    // Drop statistics: saturating counter and sticky overflow flag.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            drop_count <= 16'd0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // Payload FIFO storage.
    always_ff @(posedge AXIS_ACLK) begin
        if (pay_wr) pay_mem[pay_wr_ptr] <= s_axis.tdata;
    end

    // Payload FIFO pointers and occupancy; a simultaneous write and read leaves the count unchanged.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            pay_wr_ptr <= '0;
            pay_rd_ptr <= '0;
            pay_count  <= '0;
        end else begin
            if (pay_wr) pay_wr_ptr <= pay_wr_ptr + PAW'(1);
            if (pay_rd) pay_rd_ptr <= pay_rd_ptr + PAW'(1);
            pay_count <= pay_count + (PAW + 1)'(pay_wr) - (PAW + 1)'(pay_rd);
        end
    end

    // Length FIFO storage.
    always_ff @(posedge AXIS_ACLK) begin
        if (len_push) len_mem[len_wr_ptr] <= push_entry;
    end

    // Length FIFO pointers and occupancy.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            len_wr_ptr <= '0;
            len_rd_ptr <= '0;
            len_count  <= '0;
        end else begin
            if (len_push) len_wr_ptr <= len_wr_ptr + LAW'(1);
            if (len_pop)  len_rd_ptr <= len_rd_ptr + LAW'(1);
            len_count <= len_count + (LAW + 1)'(len_push) - (LAW + 1)'(len_pop);
        end
    end

    assign hdr_word     = {HEADER_MAGIC, CHANNEL_ID, 6'b0, hdr_q.trunc, hdr_q.tuser, hdr_q.len, seq};
    assign last_payload = (out_cnt == hdr_q.len - 16'd1);

`ifdef FRAMER_FOOTER_EN
    assign footer_word = {16'h55AA, hdr_q.len, xor_acc};
`endif

    // Output FSM state register.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) out_state <= OUT_IDLE;
        else             out_state <= out_next;
    end

    // Output FSM: pop a length entry, present header, stream payload (and footer) under TREADY.
    always_comb begin
        out_next  = out_state;
        len_pop   = 1'b0;
        pay_rd    = 1'b0;
        pkt_done  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (out_state)
            OUT_IDLE: begin
                if (len_count != '0) begin
                    len_pop  = 1'b1;
                    out_next = OUT_HEADER;
                end
            end
            OUT_HEADER: begin
                out_valid = 1'b1;
                out_data  = hdr_word;
                if (m_axis.tready) out_next = OUT_PAYLOAD;
            end
            OUT_PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = pay_mem[pay_rd_ptr];
`ifndef FRAMER_FOOTER_EN
                out_last  = last_payload;
`endif
                if (m_axis.tready) begin
                    pay_rd = 1'b1;
                    if (last_payload) begin
`ifdef FRAMER_FOOTER_EN
                        out_next = OUT_FOOTER;
`else
                        pkt_done = 1'b1;
                        out_next = OUT_IDLE;
`endif
                    end
                end
            end
            OUT_FOOTER: begin
`ifdef FRAMER_FOOTER_EN
                out_valid = 1'b1;
                out_data  = footer_word;
                out_last  = 1'b1;
                if (m_axis.tready) begin
                    pkt_done = 1'b1;
                    out_next = OUT_IDLE;
                end
`else
                out_next = OUT_IDLE;
`endif
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    // Packet context: latched length entry, payload word index, sequence and emitted-packet count.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            hdr_q       <= '0;
            out_cnt     <= 16'd0;
            seq         <= 16'd0;
            event_count <= 32'd0;
        end else begin
            if (len_pop) begin
                hdr_q   <= len_mem[len_rd_ptr];
                out_cnt <= 16'd0;
            end else if (pay_rd) begin
                out_cnt <= out_cnt + 16'd1;
            end
            if (pkt_done) begin
                seq         <= seq + 16'd1;
                event_count <= event_count + 32'd1;
            end
        end
    end

`ifdef FRAMER_FOOTER_EN
    // Footer checksum: fold each emitted payload word's halves together.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET || len_pop) xor_acc <= 32'd0;
        else if (pay_rd)            xor_acc <= xor_acc ^ out_data[31:0] ^ out_data[63:32];
    end
`endif

endmodule

// File: tb/tb_event_packet_framer.sv
// tb/tb_event_packet_framer.sv - randomized and directed self-checking bench for event_packet_framer
module tb_event_packet_framer;

    localparam int FIFO_DEPTH = 256;
    localparam int MAX_W      = 128;
    localparam int LEN_DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] evt_cnt;
    logic [15:0] drop_cnt;
    logic        ovf;

    event_packet_framer_if #(.TDATA_WIDTH(64)) s_if ();
    event_packet_framer_if #(.TDATA_WIDTH(64)) m_if ();

    event_packet_framer dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .s_axis        (s_if.slave),
        .m_axis        (m_if.master),
        .O_EVENT_COUNT (evt_cnt),
        .O_DROP_COUNT  (drop_cnt),
        .O_OVERFLOW    (ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected output stream plus buffer occupancy seen by the admission rule
    typedef struct {
        logic [63:0] data;
        bit          last;
        int          kind;   // 0 header, 1 payload, 2 footer
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] cur_words[$];
    int          occ, lenq_occ, pos, cyc, due, post_rst;
    bit          keep, cur_tuser, cur_trunc, hdr_counted, prev_stall, prev_mid, rst_prev;
    logic [31:0] m_evt;
    logic [15:0] m_drop;
    logic [15:0] m_seq;
    bit          m_ovf;
    logic [63:0] last_hdr_dut, last_tail_dut;
    int          ready_mode;

    task automatic model_clear();
        exp_q.delete();
        cur_words.delete();
        occ = 0; lenq_occ = 0; pos = 0; due = -1;
        keep = 0; cur_tuser = 0; cur_trunc = 0; hdr_counted = 0;
        prev_stall = 0; prev_mid = 0;
        m_evt = '0; m_drop = '0; m_seq = '0; m_ovf = 0;
    endtask

    task automatic build_packet();
        exp_t        e;
        logic [31:0] acc = 32'd0;
        int          n = cur_words.size();
        e.data = {16'hAA55, 8'h00, 6'b0, cur_trunc, cur_tuser, 16'(n), m_seq};
        e.last = 0; e.kind = 0;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.data = cur_words[i];
            e.kind = 1;
            acc = acc ^ cur_words[i][31:0] ^ cur_words[i][63:32];
`ifdef FRAMER_FOOTER_EN
            e.last = 0;
`else
            e.last = (i == n - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef FRAMER_FOOTER_EN
        e.data = {16'h55AA, 16'(n), acc};
        e.last = 1; e.kind = 2;
        exp_q.push_back(e);
`endif
        m_seq = m_seq + 16'd1;
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        bit   pay_pop;
        cyc++;
        pay_pop = 0;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
                chk("rst_event_count", 64'(evt_cnt), 64'd0);
                chk("rst_drop_count", 64'(drop_cnt), 64'd0);
                chk("rst_overflow", 64'(ovf), 64'd0);
            end
            model_clear();
            rst_prev = 1;
            post_rst = 0;
        end else begin
            rst_prev = 0;
            post_rst++;
            if (post_rst > 1) chk("s_tready", 64'(s_if.tready), 64'd1);
            chk("event_count", 64'(evt_cnt), 64'(m_evt));
            chk("drop_count", 64'(drop_cnt), 64'(m_drop));
            chk("overflow", 64'(ovf), 64'(m_ovf));
            if (due == cyc) begin
                chk("header_latency", 64'(m_if.tvalid), 64'd1);
                due = -1;
            end
            if (prev_stall) chk("hold_valid", 64'(m_if.tvalid), 64'd1);
            if (prev_mid)   chk("no_bubble", 64'(m_if.tvalid), 64'd1);
            prev_stall = 0;
            prev_mid   = 0;

            // output side
            if (m_if.tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(m_if.tvalid), 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("tdata", m_if.tdata, e.data);
                    chk("tlast", 64'(m_if.tlast), 64'(e.last));
                    if (e.kind == 0 && !hdr_counted) begin
                        lenq_occ--;
                        hdr_counted = 1;
                    end
                    if (m_if.tready) begin
                        void'(exp_q.pop_front());
                        if (e.kind == 0) begin
                            hdr_counted  = 0;
                            last_hdr_dut = m_if.tdata;
                        end
                        if (e.kind == 1) pay_pop = 1;
                        if (e.last) begin
                            m_evt = m_evt + 32'd1;
                            last_tail_dut = m_if.tdata;
                        end else begin
                            prev_mid = 1;
                        end
                    end else begin
                        prev_stall = 1;
                    end
                end
            end

            // input side: admission uses occupancy as it stood at the start of this cycle
            if (s_if.tvalid) begin
                if (pos == 0) begin
                    if ((FIFO_DEPTH - occ >= MAX_W) && (lenq_occ < LEN_DEPTH)) begin
                        keep = 1;
                        cur_tuser = s_if.tuser;
                        cur_trunc = 0;
                        cur_words.delete();
                    end else begin
                        keep = 0;
                        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                        m_ovf = 1;
                    end
                end
                if (keep) begin
                    if (cur_words.size() < MAX_W) begin
                        cur_words.push_back(s_if.tdata);
                        occ++;
                    end else begin
                        cur_trunc = 1;
                    end
                end
                pos++;
                if (s_if.tlast) begin
                    pos = 0;
                    if (keep) begin
                        if (exp_q.size() == 0) due = cyc + 2;
                        build_packet();
                        lenq_occ++;
                    end
                    keep = 0;
                end
            end
            if (pay_pop) occ--;
        end
    end

    // DMA ready pattern generator
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                2:       m_if.tready = ~m_if.tready;
                default: m_if.tready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    task automatic send_event(input int len, input bit tuser, input int max_gap,
                              input logic [63:0] base, input logic [63:0] step, input bit rnd);
        for (int i = 0; i < len; i++) begin
            if (max_gap > 0) begin
                int n = $urandom_range(0, max_gap);
                s_if.tvalid = 1'b0;
                repeat (n) begin @(posedge clk); #1; end
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = rnd ? {$urandom, $urandom} : base + step * 64'(i);
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = (i == 0) ? tuser : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        repeat (4) begin @(posedge clk); #1; end
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n >= 5000), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        ready_mode  = 1;
        cyc = 0;
        rst_prev = 0;
        model_clear();
        @(posedge clk); #1;
        do_reset();

        // single 4-word event
        ready_mode = 1;
        send_event(4, 1'b1, 0, 64'd1, 64'd1, 1'b0);
        drain("single");
        chk("single_header", last_hdr_dut, 64'hAA55_0001_0004_0000);
`ifdef FRAMER_FOOTER_EN
        chk("single_tail", last_tail_dut, 64'h55AA_0004_0000_0004);
`else
        chk("single_tail", last_tail_dut, 64'h4);
`endif
        chk("single_event_count", 64'(evt_cnt), 64'd1);

        // back-pressure with toggling ready
        ready_mode = 2;
        send_event(4, 1'b0, 0, 64'h10, 64'd1, 1'b0);
        drain("backpressure");
        chk("bp_header", last_hdr_dut, 64'hAA55_0000_0004_0001);

        // truncation of a 130-word event, then a following event
        ready_mode = 1;
        send_event(130, 1'b0, 0, 64'd100, 64'd1, 1'b0);
        drain("trunc");
        chk("trunc_header", last_hdr_dut, 64'hAA55_0002_0080_0002);
        send_event(1, 1'b0, 0, 64'd7, 64'd1, 1'b0);
        drain("after_trunc");
        chk("after_trunc_header", last_hdr_dut, 64'hAA55_0000_0001_0003);

        // payload overflow: third 100-word event dropped while output stalls
        ready_mode = 0;
        repeat (3) begin @(posedge clk); #1; end
        for (int k = 0; k < 3; k++) send_event(100, 1'b0, 0, 64'(k * 1000), 64'd1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        chk("ovf_drop_count", 64'(drop_cnt), 64'd1);
        chk("ovf_flag", 64'(ovf), 64'd1);
        ready_mode = 1;
        drain("overflow");
        chk("ovf_event_count", 64'(evt_cnt), 64'd6);

        // eight back-to-back 1-word events
        for (int k = 0; k < 8; k++) send_event(1, k[0], 0, 64'(k + 50), 64'd1, 1'b0);
        drain("b2b");
        chk("b2b_drop_count", 64'(drop_cnt), 64'd1);
        chk("b2b_event_count", 64'(evt_cnt), 64'd14);

        // length FIFO full while output stalls
        ready_mode = 0;
        repeat (3) begin @(posedge clk); #1; end
        for (int k = 0; k < 10; k++) send_event(1, 1'b0, 0, 64'(k + 200), 64'd1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        chk("lenq_drop_count", 64'(drop_cnt), 64'd2);
        ready_mode = 1;
        drain("lenq");
        chk("lenq_event_count", 64'(evt_cnt), 64'd23);

`ifdef FRAMER_FOOTER_EN
        send_event(2, 1'b0, 0, 64'd1, 64'd2, 1'b0);
        drain("footer");
        chk("footer_word", last_tail_dut, 64'h55AA_0002_0000_0002);
`endif

        // randomized traffic
        ready_mode = 3;
        for (int k = 0; k < 150; k++) begin
            send_event($urandom_range(1, 140), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 2 : 0, 64'd0, 64'd1, 1'b1);
        end
        drain("random");

        // reset in the middle of a packet abandons everything
        ready_mode = 2;
        send_event(30, 1'b1, 0, 64'h300, 64'd1, 1'b0);
        repeat (8) begin @(posedge clk); #1; end
        do_reset();
        ready_mode = 1;
        send_event(3, 1'b0, 0, 64'h400, 64'd1, 1'b0);
        drain("post_reset");
        chk("post_reset_header", last_hdr_dut, 64'hAA55_0000_0003_0000);
        chk("post_reset_event_count", 64'(evt_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
